// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS-like core's data-memory access path:
// request sizes, controller states and the alignment rule.
package mips_mem_pkg;

   localparam int DMEM_WORDS = 32;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RD   = 2'b01,
      S_WR   = 2'b10,
      S_RESP = 2'b11
   } state_e;

   // Size code 11 behaves as a full word.
   function automatic logic size_is_word(input logic [1:0] size);
      return size[1];
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SIZE_H) && off[0]) || (size_is_word(size) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and data-memory pin bundle for mem_access_ctrl.
// The controller uses the slave modport; the CPU/memory side uses master.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_lane_fmt.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
// Halfword lane uses off[1] only, so misaligned offsets are forced aligned.
module mem_lane_fmt
   import mips_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] rdata,
   input  logic [31:0] old,
   input  logic [31:0] wdata,
   output logic [31:0] merged
);
   logic [4:0]  byte_sh_s;
   logic [4:0]  half_sh_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_sh_s = {off, 3'b000};
   assign half_sh_s = {off[1], 4'b0000};
   assign byte_s    = 8'(word >> byte_sh_s);
   assign half_s    = 16'(word >> half_sh_s);

   // Load path: pick the lane and extend it.
   always_comb begin
      rdata = word;
      case (size)
         SIZE_B:  rdata = sign_ext ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
         SIZE_H:  rdata = sign_ext ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
         default: rdata = word;
      endcase
   end

   // Store path: replace only the addressed lane of the old word.
   always_comb begin
      merged = wdata;
      case (size)
         SIZE_B:  merged = (old & ~(32'h0000_00FF << byte_sh_s)) |
                           ({24'h000000, wdata[7:0]} << byte_sh_s);
         SIZE_H:  merged = (old & ~(32'h0000_FFFF << half_sh_s)) |
                           ({16'h0000, wdata[15:0]} << half_sh_s);
         default: merged = wdata;
      endcase
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the word-only data memory (sub-word stores via RMW).
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word requests return resp_err.
module mem_access_ctrl
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              rst,
   mem_access_ctrl_if.slave bus
);
   state_e            state_r;
   state_e            state_nx_s;
   logic [1:0]        off_r;
   logic [1:0]        size_r;
   logic              we_r;
   logic              sgn_r;
   logic [DATA_W-1:0] wdata_r;
   logic              resp_valid_r;
   logic              resp_err_r;
   logic [DATA_W-1:0] resp_rdata_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              accept_s;
   logic              misalign_s;
   logic [DATA_W-1:0] lane_rdata_s;
   logic [DATA_W-1:0] lane_merged_s;
   logic              unused_addr_s;

   assign accept_s      = (state_r == S_IDLE) && bus.req_valid;
   assign unused_addr_s = ^bus.req_addr[31:ADDR_W+2];

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_s = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
   assign misalign_s = 1'b0;
`endif

   mem_lane_fmt u_lane (
      .word     (bus.mem_rdata),
      .off      (off_r),
      .size     (size_r),
      .sign_ext (sgn_r),
      .rdata    (lane_rdata_s),
      .old      (bus.mem_rdata),
      .wdata    (wdata_r),
      .merged   (lane_merged_s)
   );

   // Next-state selection; word stores skip the read phase.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (misalign_s) begin
                  state_nx_s = S_RESP;
               end else if (bus.req_we && size_is_word(bus.req_size)) begin
                  state_nx_s = S_WR;
               end else begin
                  state_nx_s = S_RD;
               end
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_RD: begin
            if (we_r) begin
               state_nx_s = S_WR;
            end else begin
               state_nx_s = S_RESP;
            end
         end
         S_WR:    state_nx_s = S_RESP;
         S_RESP:  state_nx_s = S_IDLE;
         default: state_nx_s = S_IDLE;
      endcase
   end

   // State, request latches and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         off_r        <= 2'b00;
         size_r       <= 2'b00;
         we_r         <= 1'b0;
         sgn_r        <= 1'b0;
         wdata_r      <= '0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= '0;
         mem_addr_r   <= '0;
         mem_wdata_r  <= '0;
      end else begin
         state_r      <= state_nx_s;
         resp_valid_r <= (state_nx_s == S_RESP);
         resp_err_r   <= accept_s && misalign_s;
         if (accept_s) begin
            off_r   <= bus.req_addr[1:0];
            size_r  <= bus.req_size;
            we_r    <= bus.req_we;
            sgn_r   <= bus.req_signed;
            wdata_r <= bus.req_wdata;
         end
         // Errored requests never touch memory, so the address pins keep their value.
         if (accept_s && !misalign_s) begin
            mem_addr_r <= bus.req_addr[ADDR_W+1:2];
         end
         if (accept_s && (state_nx_s == S_WR)) begin
            mem_wdata_r <= bus.req_wdata;
         end else if ((state_r == S_RD) && we_r) begin
            mem_wdata_r <= lane_merged_s;
         end
         if ((state_r == S_RD) && !we_r) begin
            resp_rdata_r <= lane_rdata_s;
         end
      end
   end

   assign bus.req_ready  = (state_r == S_IDLE);
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_err   = resp_err_r;
   assign bus.resp_rdata = resp_rdata_r;
   assign bus.mem_we     = (state_r == S_WR) && !rst;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_wdata  = mem_wdata_r;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random requests checked
// cycle by cycle against a latency/memory-image model. Honours MEM_ALIGN_CHECK_EN.
module tb_mem_access_ctrl;
   import mips_mem_pkg::*;

   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(32)) bus ();
   mem_access_ctrl #(.ADDR_W(AW), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0] tb_mem  [DMEM_WORDS];
   logic [31:0] ref_mem [DMEM_WORDS];

   assign bus.mem_rdata = tb_mem[bus.mem_addr];
   always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: age counts cycles since acceptance (0 = idle); lat is the cycle of the
   // response, we_cyc the cycle of the memory write (0 = none).
   int          age = 0;
   int          lat = 0;
   int          we_cyc = 0;
   logic        p_err = 1'b0;
   logic        p_load = 1'b0;
   logic [4:0]  p_w = 5'd0;
   logic [31:0] p_new = 32'h0;
   logic [31:0] p_ld = 32'h0;
   logic [31:0] exp_rdata = 32'h0;

   task automatic model_accept();
      logic [31:0] a;
      logic [31:0] old;
      logic [1:0]  sz;
      int          bs;
      int          hs;
      a   = bus.req_addr;
      sz  = bus.req_size;
      p_w = a[AW+1:2];
      old = ref_mem[p_w];
`ifdef MEM_ALIGN_CHECK_EN
      if (sz == 2'd1)      p_err = (a % 2) != 0;
      else if (sz >= 2'd2) p_err = (a % 4) != 0;
      else                 p_err = 1'b0;
`else
      p_err = 1'b0;
`endif
      bs    = int'(a[1:0]) * 8;
      hs    = int'(a[1]) * 16;
      p_new = old;
      if (sz >= 2'd2) begin
         p_new = bus.req_wdata;
         p_ld  = old;
      end else if (sz == 2'd1) begin
         p_new[hs +: 16] = bus.req_wdata[15:0];
         p_ld = bus.req_signed ? {{16{old[hs+15]}}, old[hs +: 16]} : {16'h0000, old[hs +: 16]};
      end else begin
         p_new[bs +: 8] = bus.req_wdata[7:0];
         p_ld = bus.req_signed ? {{24{old[bs+7]}}, old[bs +: 8]} : {24'h000000, old[bs +: 8]};
      end
      p_load = !bus.req_we && !p_err;
      if (p_err) begin
         lat = 1; we_cyc = 0;
      end else if (bus.req_we) begin
         lat = (sz >= 2'd2) ? 2 : 3;
         we_cyc = lat - 1;
      end else begin
         lat = 2; we_cyc = 0;
      end
      age = 1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         age = 0;
         exp_rdata = 32'h0;
      end else if (age != 0) begin
         if (age == we_cyc) ref_mem[p_w] = p_new;
         if (age == lat) begin
            age = 0;
         end else begin
            age = age + 1;
            if (age == lat && p_load) exp_rdata = p_ld;
         end
      end else if (bus.req_valid) begin
         model_accept();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(bus.req_ready), 32'(age == 0));
         chk("resp_valid", 32'(bus.resp_valid), 32'(age != 0 && age == lat));
         chk("mem_we", 32'(bus.mem_we), 32'(age != 0 && age == we_cyc && !rst));
         chk("resp_rdata", bus.resp_rdata, exp_rdata);
         if (age != 0 && age == lat) chk("resp_err", 32'(bus.resp_err), 32'(p_err));
         if (age != 0 && age < lat && !p_err) chk("mem_addr", 32'(bus.mem_addr), 32'(p_w));
         if (age != 0 && age == we_cyc && !rst) chk("mem_wdata", bus.mem_wdata, p_new);
      end
   end

   // Issue one request, wait for acceptance and response; other request fields are
   // scrambled after acceptance so any missing latch shows up.
   task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat_o, output int we_n);
      int n;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
      bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: actual ready=0 required ready=1 within 20 cycles");
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.req_we = 1'($urandom_range(0, 1));
      bus.req_size = 2'($urandom_range(0, 3)); bus.req_signed = 1'($urandom_range(0, 1));
      bus.req_addr = $urandom(); bus.req_wdata = $urandom();
      rd = 32'h0; er = 1'b0; lat_o = 0; we_n = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (bus.mem_we) we_n++;
         if (bus.resp_valid) begin
            lat_o = i; rd = bus.resp_rdata; er = bus.resp_err;
            break;
         end
      end
      if (lat_o == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL resp_timeout: actual no resp_valid required resp_valid within 8 cycles");
      end
      @(posedge clk); #1;
   endtask

   // Random request cut short by a one-cycle reset k cycles after acceptance.
   task automatic abort_req(input int k);
      bus.req_valid = 1'b1; bus.req_we = 1'($urandom_range(0, 1));
      bus.req_size = 2'($urandom_range(0, 3)); bus.req_signed = 1'($urandom_range(0, 1));
      bus.req_addr = $urandom(); bus.req_wdata = $urandom();
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (k) begin @(posedge clk); #1; end
      rst = 1'b1; bus.req_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      rst = 1'b0; bus.req_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lt;
      int          wn;
      int          pulses;
      for (int i = 0; i < DMEM_WORDS; i++) begin
         tb_mem[i]  = 32'hAAAA_AAAA;
         ref_mem[i] = 32'hAAAA_AAAA;
      end
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);

      run_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, er, lt, wn);
      chk("ldw_data", rd, 32'hAAAA_AAAA);
      chk("ldw_err", 32'(er), 32'd0);
      chk("ldw_lat", 32'(lt), 32'd2);

      run_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h1234_5678, rd, er, lt, wn);
      chk("stw_lat", 32'(lt), 32'd2);
      chk("stw_we_cycles", 32'(wn), 32'd1);
      run_req(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, rd, er, lt, wn);
      chk("ldb_signed_0b", rd, 32'h0000_0012);
      run_req(1'b0, 2'b01, 1'b0, 32'h08, 32'h0, rd, er, lt, wn);
      chk("ldh_unsigned_08", rd, 32'h0000_5678);

      run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00FF, rd, er, lt, wn);
      chk("stb_lat", 32'(lt), 32'd3);
      chk("stb_we_cycles", 32'(wn), 32'd1);
      chk("stb_mem_w4", tb_mem[4], 32'hAAAA_FFAA);
      chk("model_w4", ref_mem[4], 32'hAAAA_FFAA);
      run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, er, lt, wn);
      chk("ldb_signed_11", rd, 32'hFFFF_FFFF);

      run_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_BEEF, rd, er, lt, wn);
      chk("sth13_rdata_held", rd, 32'hFFFF_FFFF);
`ifdef MEM_ALIGN_CHECK_EN
      chk("sth13_err", 32'(er), 32'd1);
      chk("sth13_lat", 32'(lt), 32'd1);
      chk("sth13_we_cycles", 32'(wn), 32'd0);
      chk("sth13_mem_w4", tb_mem[4], 32'hAAAA_FFAA);
`else
      chk("sth13_err", 32'(er), 32'd0);
      chk("sth13_lat", 32'(lt), 32'd3);
      chk("sth13_mem_w4", tb_mem[4], 32'hBEEF_FFAA);
`endif

      // Byte store to 0x20 with reset during its read cycle; a load is held on req_valid meanwhile.
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'h55;
      @(posedge clk); #1;
      bus.req_we = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.req_valid = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("abort_rdata", bus.resp_rdata, 32'h0);
      chk("abort_mem_w8", tb_mem[8], 32'hAAAA_AAAA);
      @(posedge clk); #1;

      run_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFE_F00D, rd, er, lt, wn);
      chk("wrap_mem_w0", tb_mem[0], 32'hCAFE_F00D);

      // req_valid held high with aligned word loads: one response every 3 cycles.
      pulses = 0;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
      bus.req_addr = $urandom() & 32'hFFFF_FFFC;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         bus.req_addr = $urandom() & 32'hFFFF_FFFC;
         @(negedge clk);
         if (bus.resp_valid) pulses++;
      end
      bus.req_valid = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd10);
      @(posedge clk); #1;

      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 19) == 0) begin
            abort_req(int'($urandom_range(0, 3)));
         end else begin
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom(), $urandom(), rd, er, lt, wn);
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < DMEM_WORDS; w++) chk("mem_image", tb_mem[w], ref_mem[w]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator for the single-cycle MIPS-like core's word-only data memory. It accepts one CPU request at a time: byte, halfword or word, load or store. It drives the data memory's write-enable, word-address and write-data pins and captures its combinational read data. Sub-word stores are done as read-modify-write, because the memory has no byte enables. It sits between the datapath's MEM stage and the data memory instance.

## Interface
- `ADDR_W`, default 5: word-address width of the data memory (32 words).
- `DATA_W`, default 32: data width; only 32 is supported.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  controller can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `req_signed`  in  1  loads only: sign-extend (1) or zero-extend (0).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; holds its value until the next load completes.
- `resp_err`  out  1  misaligned request; valid only with `resp_valid`.
- `mem_we`  out  1  data memory write enable.
- `mem_addr`  out  ADDR_W  word address, equal to `req_addr[ADDR_W+1:2]`.
- `mem_wdata`  out  32  data memory write data.
- `mem_rdata`  in  32  data memory read data, combinational from `mem_addr`.

## Operation
- States: IDLE, RD, WR, RESP.
- Handshake: the request is accepted on a posedge where `req_valid && req_ready`. At acceptance, addr, size, we, signed and wdata are latched.
- Load: IDLE → RD → RESP → IDLE.
  - In RD, `mem_rdata` is captured.
  - Byte lanes are little-endian: the byte lane is `addr[1:0]`, the half lane is `addr[1]`.
  - The selected lane is extracted and extended per `req_signed`.
- Store word: IDLE → WR → RESP. `mem_we`=1 for exactly the WR cycle, with `mem_wdata` = the latched wdata.
- Store byte/half: IDLE → RD → WR → RESP.
  - In RD, the old word is captured.
  - In WR, `mem_wdata` = the old word with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`.
- RESP: `resp_valid`=1 for one cycle; the next state is always IDLE. A new request is accepted only after the controller returns to IDLE.
- `mem_addr` is driven from the latched address in RD and WR, and holds its last value otherwise.
- Address bits above `ADDR_W+1` are ignored, so addresses wrap modulo 128 bytes.
- `mem_we` = (state==WR) && !rst. A write is suppressed in any cycle where `rst` is high.
- Reset values: state IDLE, so `req_ready`=1. `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation: the request in flight is aborted with no response and no write. If the reset occurs in RD of a sub-word store, memory is left untouched.
- `req_valid` asserted together with `rst` is ignored.

## Timing
- From the acceptance edge to `resp_valid` high: load 2 cycles, store word 2 cycles, store byte/half 3 cycles.
- Back-to-back requests: one every 3 cycles (word or load), or every 4 cycles (sub-word store), since `req_ready` returns high in the cycle after RESP.
- The `mem_rdata` path is combinational through the memory; it is captured at the end of RD, so there is no same-cycle dependence on outputs.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A halfword with `addr[0]`≠0, or a word with `addr[1:0]`≠0, skips RD and WR and goes IDLE → RESP with `resp_err`=1.
  - No memory write occurs, and `resp_rdata` is unchanged.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Misaligned offsets are forced aligned: halfword uses `addr[1]` only; word ignores `addr[1:0]`.
  - `resp_err` is tied to 0.

## Structure
- Shared package `mips_mem_pkg`:
  - Size encodings SIZE_B, SIZE_H, SIZE_W.
  - State encodings S_IDLE, S_RD, S_WR, S_RESP.
  - Constant DMEM_WORDS=32.
- Sub-module `mem_lane_fmt` (combinational) owns both lane operations:
  - Load extract/extend: in `word`, `off`, `size`, `signed`; out `rdata`.
  - Store merge: in `old`, `wdata`, `off`, `size`; out `merged`.
- The top level holds the FSM and the request registers.

## Test plan
- After reset, with memory initialised to 0xAAAAAAAA: load word at addr 0x04 → `resp_rdata`=0xAAAAAAAA two cycles after acceptance, `resp_err`=0.
- Store word 0x12345678 at 0x08, then load byte signed at 0x0B → 0x00000012. Load half unsigned at 0x08 → 0x00005678.
- Store byte 0xFF at 0x11 over 0xAAAAAAAA → memory word 4 = 0xAAAAFFAA. `mem_we` is high exactly one cycle and `resp_valid` comes 3 cycles after acceptance. A following load byte signed at 0x11 → 0xFFFFFFFF.
- Half store at 0x13:
  - With `MEM_ALIGN_CHECK_EN`: `resp_err`=1 one cycle after acceptance, `mem_we` never high, memory unchanged.
  - Without it: lane `addr[1]`=1 is written.
- Assert `rst` in the RD cycle of a byte store to 0x20 → no `mem_we`, no `resp_valid`, `req_ready`=1 the next cycle, word 8 unchanged.
- Store word at 0x80 → writes word 0 (wrap). Hold `req_valid` high continuously → one acceptance per `req_ready` window, and no acceptance while busy.
